// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
// State codes, LCD command bytes and the power-on init table.
package lcd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_PWRUP = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_SETUP = 3'd2;
  localparam state_t S_PULSE = 3'd3;
  localparam state_t S_HOLD  = 3'd4;
  localparam state_t S_WAIT  = 3'd5;
  localparam state_t S_IDLE  = 3'd6;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  localparam int INIT_LEN = 6;

  typedef struct packed {
    logic [7:0] cmd;
    logic       long_wait;
  } init_ent_t;

  function automatic init_ent_t init_rom(input logic [2:0] idx);
    init_ent_t e;
    unique case (idx)
      3'd0:    e = '{cmd: CMD_FUNC_SET, long_wait: 1'b1};
      3'd1:    e = '{cmd: CMD_FUNC_SET, long_wait: 1'b0};
      3'd2:    e = '{cmd: CMD_FUNC_SET, long_wait: 1'b0};
      3'd3:    e = '{cmd: CMD_DISP_ON,  long_wait: 1'b0};
      3'd4:    e = '{cmd: CMD_CLEAR,    long_wait: 1'b1};
      3'd5:    e = '{cmd: CMD_ENTRY,    long_wait: 1'b0};
      default: e = '{cmd: CMD_ENTRY,    long_wait: 1'b0};
    endcase
    return e;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_init_seq.sv
// Power-on init table walker: entry index plus ROM lookup.
// The index parks on the last entry once init completes.
module lcd_init_seq
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       next,
  output logic [7:0] data,
  output logic       long_wait,
  output logic       last
);

  logic [2:0] idx;
  init_ent_t  ent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (next && !last) begin
      idx <= idx + 3'd1;
    end
  end

  always_comb begin
    ent       = init_rom(idx);
    data      = ent.cmd;
    long_wait = ent.long_wait;
    last      = (idx == 3'(INIT_LEN - 1));
  end

endmodule

// File: rtl/lcd_writer.sv
// HD44780 write controller: autonomous init, then one byte per
// valid/ready handshake with setup/enable/hold/wait bus timing.
module lcd_writer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int PWRUP_CYC     = 750000,
  parameter int SETUP_CYC     = 3,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int LONG_WAIT_CYC = 205000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       bl_en,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int MAXC = max_of(max_of(max_of(PWRUP_CYC, SETUP_CYC),
                        max_of(EN_CYC, HOLD_CYC)),
                        max_of(CMD_WAIT_CYC, LONG_WAIT_CYC));
  localparam int CW = $clog2(MAXC) + 1;

  if (CLK_HZ <= 0) begin : g_bad_clk
    $error("CLK_HZ must be positive");
  end

  state_t     state;
  logic [CW-1:0] cnt;
  logic       cnt_zero;
  logic       seq_next;
  logic       seq_last;
  logic       seq_long;
  logic [7:0] seq_data;
  logic       long_sel;

  lcd_init_seq u_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (seq_next),
    .data      (seq_data),
    .long_wait (seq_long),
    .last      (seq_last)
  );

  assign cnt_zero = (cnt == '0);
  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;
  assign lcd_rw   = 1'b0;
  assign seq_next = (state == S_WAIT) && cnt_zero && !init_done;

  // Clear/home need the long wait; the first init entry is flagged in the ROM.
  assign long_sel = (!init_done && seq_long) ||
                    (!lcd_rs && (lcd_data inside {CMD_CLEAR, CMD_HOME, 8'h03}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_PWRUP;
      cnt       <= CW'(PWRUP_CYC - 1);
      init_done <= 1'b0;
      lcd_on    <= 1'b0;
      lcd_blon  <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      lcd_on   <= 1'b1;
      lcd_blon <= bl_en;
      unique case (state)
        S_PWRUP: begin
          if (cnt_zero) state <= S_LOAD;
          else          cnt   <= cnt - 1'b1;
        end
        S_LOAD: begin
          lcd_rs   <= 1'b0;
          lcd_data <= seq_data;
          cnt      <= CW'(SETUP_CYC - 1);
          state    <= S_SETUP;
        end
        S_SETUP: begin
          if (cnt_zero) begin
            lcd_en <= 1'b1;
            cnt    <= CW'(EN_CYC - 1);
            state  <= S_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            lcd_en <= 1'b0;
            cnt    <= CW'(HOLD_CYC - 1);
            state  <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            cnt   <= long_sel ? CW'(LONG_WAIT_CYC - 1)
                              : CW'(CMD_WAIT_CYC - 1);
            state <= S_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_zero) begin
            if (init_done) begin
              state <= S_IDLE;
            end else if (seq_last) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            lcd_rs   <= in_rs;
            lcd_data <= in_data;
            cnt      <= CW'(SETUP_CYC - 1);
            state    <= S_SETUP;
          end
        end
        default: begin
          state <= S_PWRUP;
          cnt   <= CW'(PWRUP_CYC - 1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench for lcd_writer: expected bytes are queued by the
// stimulus and checked by a monitor on every lcd_en pulse.
module tb_lcd_writer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       bl_en = 1'b0;
  logic       init_done;
  logic       busy;
  logic       lcd_on;
  logic       lcd_blon;
  logic       lcd_en;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  bit done = 1'b0;

  logic [8:0] exp_q[$];
  logic [8:0] cur_e;
  logic       en_prev = 1'b0;
  int         hi = 0;
  logic       bl_q;

  lcd_writer #(
    .CLK_HZ(50000000), .PWRUP_CYC(20), .SETUP_CYC(3), .EN_CYC(12),
    .HOLD_CYC(2), .CMD_WAIT_CYC(10), .LONG_WAIT_CYC(40)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .in_ready(in_ready), .in_rs(in_rs), .in_data(in_data),
    .bl_en(bl_en), .init_done(init_done), .busy(busy),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon), .lcd_en(lcd_en),
    .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) bl_q <= 1'b0;
    else          bl_q <= bl_en;

  // Monitor: pops one expected byte per enable pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      en_prev = 1'b0;
      hi = 0;
    end else begin
      chk("rw_zero", 32'(lcd_rw), 32'd0);
      chk("blon", 32'(lcd_blon), 32'(bl_q));
      if (lcd_en && !en_prev) begin
        pulses++;
        hi = 1;
        if (exp_q.size() == 0) begin
          cur_e = 9'h1ff;
          chk("unexpected_pulse", 32'({lcd_rs, lcd_data}), 32'h1ff);
        end else begin
          cur_e = exp_q.pop_front();
          chk("pulse_byte", 32'({lcd_rs, lcd_data}), 32'(cur_e));
        end
      end else if (lcd_en) begin
        hi++;
      end else if (en_prev) begin
        chk("en_width", 32'(hi), 32'd12);
        chk("byte_stable", 32'({lcd_rs, lcd_data}), 32'(cur_e));
      end
      en_prev = lcd_en;
    end
  end

  initial begin
    while (!done) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      bl_en = ~bl_en;
    end
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic wait_init();
    int n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (init_done || in_ready) break;
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_ready", 32'(in_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (n < 500 && !in_ready) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d,
                      input int lat, input string nm);
    int n;
    int en_at;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_rs = rs;
    in_data = d;
    exp_q.push_back({rs, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_rs"}, 32'(lcd_rs), 32'(rs));
    chk({nm, "_data"}, 32'(lcd_data), 32'(d));
    n = 0;
    en_at = -1;
    while (n < 500) begin
      @(posedge clk);
      n++;
      #1;
      if (lcd_en && en_at < 0) en_at = n;
      if (in_ready) break;
    end
    chk({nm, "_en_at"}, 32'(en_at), 32'd3);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
  endtask

  initial begin
    int p0;
    int n;
    logic r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_en", 32'(lcd_en), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_on", 32'(lcd_on), 32'd0);
    chk("rst_blon", 32'(lcd_blon), 32'd0);

    push_init();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("lcd_on_rise", 32'(lcd_on), 32'd1);
    wait_init();
    chk("init_pulses", 32'(pulses), 32'd6);
    chk("init_q_empty", 32'(exp_q.size()), 32'd0);

    send(1'b1, 8'h41, 27, "char_A");
    send(1'b0, 8'h01, 57, "clear");
    send(1'b1, 8'h01, 27, "char_01");
    send(1'b0, 8'h02, 57, "home");
    send(1'b0, 8'h03, 57, "home_alt");
    send(1'b0, 8'h04, 27, "cmd_04");

    // Back-to-back with in_valid held high.
    @(negedge clk);
    p0 = pulses;
    in_valid = 1'b1;
    in_rs = 1'b1;
    in_data = 8'h48;
    exp_q.push_back({1'b1, 8'h48});
    exp_q.push_back({1'b1, 8'h49});
    @(posedge clk);
    #1;
    chk("b2b_first", 32'(lcd_data), 32'h48);
    in_data = 8'h49;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      n++;
      if (r) break;
    end
    #1;
    in_valid = 1'b0;
    chk("b2b_gap", 32'(n), 32'd28);
    chk("b2b_second", 32'(lcd_data), 32'h49);
    chk("b2b_rdy_drop", 32'(in_ready), 32'd0);
    wait_ready("b2b");
    repeat (10) @(negedge clk);
    chk("b2b_pulses", 32'(pulses - p0), 32'd2);
    chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of an enable pulse.
    @(negedge clk);
    in_valid = 1'b1;
    in_rs = 1'b1;
    in_data = 8'h55;
    exp_q.push_back({1'b1, 8'h55});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 50 && !lcd_en) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_en_seen", 32'(lcd_en), 32'd1);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(lcd_en), 32'd0);
    chk("mid_rst_init", 32'(init_done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_data", 32'(lcd_data), 32'd0);
    chk("mid_rst_rs", 32'(lcd_rs), 32'd0);
    chk("mid_rst_on", 32'(lcd_on), 32'd0);
    p0 = pulses;
    push_init();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    chk("replay_pulses", 32'(pulses - p0), 32'd6);
    chk("replay_q_empty", 32'(exp_q.size()), 32'd0);

    send(1'b1, 8'h5A, 27, "post_rst");
    repeat (5) @(negedge clk);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
